// File: rtl/neuron_sweep_ctrl.sv
// Sweep sequencer for the shared IF neuron datapath: read state/weight, strobe event, write back.
// Optional NEURON_SWEEP_SPKCNT_EN adds tstep_spk_cnt (spikes seen in the latest time-step sweep).
module neuron_sweep_ctrl #(
    parameter int N_POST = 256,
    parameter int POST_W = 8,
    parameter int PRE_W  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [PRE_W-1:0]        cmd_addr,
    output logic                    st_rd_en,
    output logic [POST_W-1:0]       st_rd_addr,
    output logic                    wt_rd_en,
    output logic [PRE_W+POST_W-1:0] wt_rd_addr,
    output logic                    st_wr_en,
    output logic [POST_W-1:0]       st_wr_addr,
    output logic                    neuron_event,
    output logic                    time_step_event,
    output logic                    time_ref_event,
    input  logic                    spike_in,
    output logic                    spk_out_valid,
    output logic [POST_W-1:0]       spk_out_addr,
    output logic                    sweep_done,
    output logic                    cmd_err
`ifdef NEURON_SWEEP_SPKCNT_EN
    ,
    output logic [POST_W:0]         tstep_spk_cnt
`endif
);

    localparam logic [1:0] T_SPK   = 2'd0;
    localparam logic [1:0] T_TSTEP = 2'd1;
    localparam logic [1:0] T_TREF  = 2'd2;
    localparam logic [1:0] T_ILL   = 2'd3;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t              state, nxt;
    logic [POST_W-1:0]   cnt;
    logic [1:0]          typ;
    logic [PRE_W-1:0]    pre;
    logic                s2_vld;
    logic [POST_W-1:0]   s2_addr;
    logic                accept, start, last, fire;

    // Ready is forced low while reset is held, not just after the first edge.
    assign cmd_ready = (state == IDLE) && !RST;
    assign accept    = cmd_valid && cmd_ready;
    assign start     = accept && (cmd_type != T_ILL);
    assign last      = (cnt == POST_W'(N_POST - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt        = state;
        st_rd_en   = 1'b0;
        st_rd_addr = '0;
        wt_rd_en   = 1'b0;
        wt_rd_addr = '0;
        sweep_done = 1'b0;
        case (state)
            IDLE: if (start) nxt = SWEEP;
            SWEEP: begin
                st_rd_en   = 1'b1;
                st_rd_addr = cnt;
                if (typ == T_SPK) begin
                    wt_rd_en   = 1'b1;
                    wt_rd_addr = {pre, cnt};
                end
                if (last) nxt = DRAIN;
            end
            DRAIN: begin
                sweep_done = 1'b1;
                nxt        = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Stage 2: write-back of the address read one cycle earlier; typ is stable until IDLE.
    assign st_wr_en        = s2_vld;
    assign st_wr_addr      = s2_vld ? s2_addr : '0;
    assign neuron_event    = s2_vld && (typ == T_SPK);
    assign time_step_event = s2_vld && (typ == T_TSTEP);
    assign time_ref_event  = s2_vld && (typ == T_TREF);
    assign fire            = spike_in && time_step_event;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt           <= '0;
            typ           <= T_SPK;
            pre           <= '0;
            s2_vld        <= 1'b0;
            s2_addr       <= '0;
            spk_out_valid <= 1'b0;
            spk_out_addr  <= '0;
            cmd_err       <= 1'b0;
        end else begin
            cmd_err       <= accept && (cmd_type == T_ILL);
            s2_vld        <= st_rd_en;
            s2_addr       <= cnt;
            spk_out_valid <= fire;
            if (fire) spk_out_addr <= st_wr_addr;
            if (start) begin
                typ <= cmd_type;
                pre <= cmd_addr;
                cnt <= '0;
            end else if (st_rd_en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef NEURON_SWEEP_SPKCNT_EN
    // A late spike from the previous sweep is dropped when a new time-step sweep clears the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                tstep_spk_cnt <= '0;
        else if (start && cmd_type == T_TSTEP)  tstep_spk_cnt <= '0;
        else if (spk_out_valid)                 tstep_spk_cnt <= tstep_spk_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// Bench for neuron_sweep_ctrl: directed vector table, cycle model with random commands, corner sequences.
// Honours NEURON_SWEEP_SPKCNT_EN when defined.
module tb_neuron_sweep_ctrl;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int RW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_type;
    logic [RW-1:0]     cmd_addr;
    logic              st_rd_en, wt_rd_en, st_wr_en;
    logic [PW-1:0]     st_rd_addr, st_wr_addr, spk_out_addr;
    logic [RW+PW-1:0]  wt_rd_addr;
    logic              neuron_event, time_step_event, time_ref_event;
    logic              spike_in, spk_out_valid, sweep_done, cmd_err;
`ifdef NEURON_SWEEP_SPKCNT_EN
    logic [PW:0]       tstep_spk_cnt;
    logic [1:0]        u1_cnt;
`endif

    logic              u1_valid, u1_ready, u1_rd, u1_wt, u1_wr;
    logic [1:0]        u1_type;
    logic [7:0]        u1_addr;
    logic [0:0]        u1_rda, u1_wra, u1_sa;
    logic [8:0]        u1_wta;
    logic              u1_ne, u1_te, u1_re, u1_spike, u1_sv, u1_done, u1_err;

    neuron_sweep_ctrl #(.N_POST(N), .POST_W(PW), .PRE_W(RW)) dut (
        .CLK(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .st_rd_en(st_rd_en), .st_rd_addr(st_rd_addr),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .st_wr_en(st_wr_en), .st_wr_addr(st_wr_addr),
        .neuron_event(neuron_event), .time_step_event(time_step_event),
        .time_ref_event(time_ref_event), .spike_in(spike_in), .spk_out_valid(spk_out_valid),
        .spk_out_addr(spk_out_addr), .sweep_done(sweep_done), .cmd_err(cmd_err)
`ifdef NEURON_SWEEP_SPKCNT_EN
        , .tstep_spk_cnt(tstep_spk_cnt)
`endif
    );

    neuron_sweep_ctrl #(.N_POST(1), .POST_W(1), .PRE_W(8)) dut1 (
        .CLK(clk), .RST(rst), .cmd_valid(u1_valid), .cmd_ready(u1_ready),
        .cmd_type(u1_type), .cmd_addr(u1_addr), .st_rd_en(u1_rd), .st_rd_addr(u1_rda),
        .wt_rd_en(u1_wt), .wt_rd_addr(u1_wta), .st_wr_en(u1_wr), .st_wr_addr(u1_wra),
        .neuron_event(u1_ne), .time_step_event(u1_te), .time_ref_event(u1_re),
        .spike_in(u1_spike), .spk_out_valid(u1_sv), .spk_out_addr(u1_sa),
        .sweep_done(u1_done), .cmd_err(u1_err)
`ifdef NEURON_SWEEP_SPKCNT_EN
        , .tstep_spk_cnt(u1_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0;

    always @(negedge clk) if (sweep_done) n_done++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic rd,
                           input logic [PW-1:0] rda, input logic wt, input logic [RW+PW-1:0] wta,
                           input logic wr, input logic [PW-1:0] wra, input logic [2:0] ev,
                           input logic sv, input logic [PW-1:0] sa, input logic dn, input logic er);
        chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'(rdy));
        chk({tag, ".st_rd_en"},   32'(st_rd_en),   32'(rd));
        chk({tag, ".st_rd_addr"}, 32'(st_rd_addr), 32'(rda));
        chk({tag, ".wt_rd_en"},   32'(wt_rd_en),   32'(wt));
        chk({tag, ".wt_rd_addr"}, 32'(wt_rd_addr), 32'(wta));
        chk({tag, ".st_wr_en"},   32'(st_wr_en),   32'(wr));
        chk({tag, ".st_wr_addr"}, 32'(st_wr_addr), 32'(wra));
        chk({tag, ".events"},     32'({time_ref_event, time_step_event, neuron_event}), 32'(ev));
        chk({tag, ".spk_valid"},  32'(spk_out_valid), 32'(sv));
        if (sv) chk({tag, ".spk_addr"}, 32'(spk_out_addr), 32'(sa));
        chk({tag, ".sweep_done"}, 32'(sweep_done), 32'(dn));
        chk({tag, ".cmd_err"},    32'(cmd_err),    32'(er));
    endtask

    // Reference model: position in the current command, counted in cycles since acceptance.
    logic          m_busy = 1'b0;
    int            m_c = 0;
    logic [1:0]    m_typ = 2'd0;
    logic [RW-1:0] m_pre = '0;
    logic          m_err = 1'b0;
    logic          m_spk = 1'b0;
    logic [PW-1:0] m_spa = '0;
    int            m_cnt = 0;

    task automatic step(input logic v, input logic [1:0] t, input logic [RW-1:0] a, input logic s);
        logic e_rd, e_wt, e_wr, n_err, n_spk;
        logic [PW-1:0] n_spa;
        cmd_valid = v; cmd_type = t; cmd_addr = a; spike_in = s;
        @(negedge clk);
        e_rd = m_busy && (m_c <= N);
        e_wr = m_busy && (m_c >= 2);
        e_wt = e_rd && (m_typ == 2'd0);
        chk_all("model", !m_busy, e_rd, e_rd ? PW'(m_c - 1) : '0,
                e_wt, e_wt ? {m_pre, PW'(m_c - 1)} : '0,
                e_wr, e_wr ? PW'(m_c - 2) : '0, e_wr ? (3'b001 << m_typ) : 3'b000,
                m_spk, m_spa, m_busy && (m_c == N + 1), m_err);
`ifdef NEURON_SWEEP_SPKCNT_EN
        chk("model.spk_cnt", 32'(tstep_spk_cnt), 32'(m_cnt));
`endif
        @(posedge clk);
        n_err = !m_busy && v && (t == 2'd3);
        n_spk = e_wr && (m_typ == 2'd1) && s;
        n_spa = PW'(m_c - 2);
        if (!m_busy && v && t == 2'd1) m_cnt = 0;
        else if (m_spk)                m_cnt++;
        if (m_busy) begin
            if (m_c == N + 1) m_busy = 1'b0;
            else              m_c++;
        end else if (v && t != 2'd3) begin
            m_busy = 1'b1; m_c = 1; m_typ = t; m_pre = a;
        end
        m_err = n_err;
        m_spk = n_spk;
        if (n_spk) m_spa = n_spa;
        #1;
    endtask

    typedef struct {
        logic v; logic [1:0] t; logic [RW-1:0] a; logic s;
        logic rdy; logic rd; logic [PW-1:0] rda; logic wt; logic [RW+PW-1:0] wta;
        logic wr; logic [PW-1:0] wra; logic [2:0] ev; logic sv; logic [PW-1:0] sa;
        logic dn; logic er;
    } vec_t;

    function automatic vec_t mk(int v, int t, int a, int s, int rdy, int rd, int rda, int wt,
                                int wta, int wr, int wra, int ev, int sv, int sa, int dn, int er);
        vec_t r;
        r.v = 1'(v); r.t = 2'(t); r.a = RW'(a); r.s = 1'(s);
        r.rdy = 1'(rdy); r.rd = 1'(rd); r.rda = PW'(rda); r.wt = 1'(wt); r.wta = (RW+PW)'(wta);
        r.wr = 1'(wr); r.wra = PW'(wra); r.ev = 3'(ev); r.sv = 1'(sv); r.sa = PW'(sa);
        r.dn = 1'(dn); r.er = 1'(er);
        return r;
    endfunction

    vec_t tbl[14];
    logic pv;
    logic [1:0] pt;
    logic [RW-1:0] pa;
    logic was_idle;

    initial begin
        cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = '0; spike_in = 1'b0;
        u1_valid = 1'b0; u1_type = 2'd0; u1_addr = 8'd0; u1_spike = 1'b0;

        //            v t a s  rdy rd rda wt wta    wr wra ev sv sa dn er
        tbl[0]  = mk(1,0,5,0, 1, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0,0,0,0, 0, 1, 0, 1, 'h500,  0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0,0,0,0, 0, 1, 1, 1, 'h501,  1, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0,0,0,0, 0, 1, 2, 1, 'h502,  1, 1, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0,0,0,0, 0, 1, 3, 1, 'h503,  1, 2, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0,0,0,0, 0, 0, 0, 0, 0,      1, 3, 1, 0, 0, 1, 0);
        tbl[6]  = mk(1,3,0,0, 1, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1,1,0,0, 1, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(0,0,0,0, 0, 1, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0,0,0,0, 0, 1, 1, 0, 0,      1, 0, 2, 0, 0, 0, 0);
        tbl[10] = mk(0,0,0,0, 0, 1, 2, 0, 0,      1, 1, 2, 0, 0, 0, 0);
        tbl[11] = mk(0,0,0,1, 0, 1, 3, 0, 0,      1, 2, 2, 0, 0, 0, 0);
        tbl[12] = mk(0,0,0,0, 0, 0, 0, 0, 0,      1, 3, 2, 1, 2, 1, 0);
        tbl[13] = mk(0,0,0,0, 1, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0);

        // Reset values, then ready rises on release.
        @(negedge clk);
        chk_all("reset", 0, 0, '0, 0, '0, 0, '0, 3'b000, 0, '0, 0, 0);
        rst = 1'b0;
        #1 chk("release.cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            cmd_valid = tbl[i].v; cmd_type = tbl[i].t; cmd_addr = tbl[i].a; spike_in = tbl[i].s;
            @(negedge clk);
            chk_all($sformatf("tbl[%0d]", i), tbl[i].rdy, tbl[i].rd, tbl[i].rda, tbl[i].wt,
                    tbl[i].wta, tbl[i].wr, tbl[i].wra, tbl[i].ev, tbl[i].sv, tbl[i].sa,
                    tbl[i].dn, tbl[i].er);
            @(posedge clk); #1;
        end
        m_cnt = 1;
`ifdef NEURON_SWEEP_SPKCNT_EN
        @(negedge clk);
        chk("tbl.spk_cnt", 32'(tstep_spk_cnt), 32'd1);
        @(posedge clk); #1;
`endif

        // Time-ref sweep.
        step(1'b1, 2'd2, 8'h33, 1'b1);
        for (int i = 0; i < N + 2; i++) step(1'b0, 2'd0, 8'h00, 1'b1);

        // Command held valid through a sweep: second one accepted at cycle N+2.
        n_done = 0;
        for (int i = 0; i < 2 * (N + 2); i++) step(1'b1, 2'd1, 8'h11, 1'($urandom_range(0, 1)));
        chk("held.sweep_count", 32'(n_done), 32'd2);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);

        // Random commands with a requester that holds valid until accepted.
        pv = 1'b0; pt = 2'd0; pa = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pv && $urandom_range(0, 2) == 0) begin
                pv = 1'b1; pt = 2'($urandom_range(0, 3)); pa = RW'($urandom);
            end
            was_idle = !m_busy;
            step(pv, pt, pa, 1'($urandom_range(0, 1)));
            if (pv && was_idle) pv = 1'b0;
        end
        for (int i = 0; i < N + 3; i++) step(1'b0, 2'd0, 8'h00, 1'b0);

        // Reset during cycle 3 of a sweep.
        n_done = 0;
        step(1'b1, 2'd0, 8'h09, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all("rst_mid", 0, 0, '0, 0, '0, 0, '0, 3'b000, 0, '0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.no_done", 32'(n_done), 32'd0);
        @(posedge clk); #1;
        m_busy = 1'b0; m_err = 1'b0; m_spk = 1'b0; m_cnt = 0;
        step(1'b1, 2'd0, 8'h03, 1'b0);
        for (int i = 0; i < N + 2; i++) step(1'b0, 2'd0, 8'h00, 1'b0);
        chk("rst_mid.resweep_done", 32'(n_done), 32'd1);

        // N_POST = 1 instance: one read, DRAIN next, sweep_done in cycle 2.
        u1_valid = 1'b1; u1_type = 2'd0; u1_addr = 8'd7;
        @(negedge clk);
        chk("n1.c0.ready", 32'(u1_ready), 32'd1);
        chk("n1.c0.rd", 32'(u1_rd), 32'd0);
        @(posedge clk); #1;
        u1_valid = 1'b0;
        @(negedge clk);
        chk("n1.c1.rd", 32'(u1_rd), 32'd1);
        chk("n1.c1.rda", 32'(u1_rda), 32'd0);
        chk("n1.c1.wt", 32'(u1_wt), 32'd1);
        chk("n1.c1.wta", 32'(u1_wta), 32'h0E);
        chk("n1.c1.done", 32'(u1_done), 32'd0);
        chk("n1.c1.ready", 32'(u1_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n1.c2.wr", 32'(u1_wr), 32'd1);
        chk("n1.c2.wra", 32'(u1_wra), 32'd0);
        chk("n1.c2.events", 32'({u1_re, u1_te, u1_ne}), 32'd1);
        chk("n1.c2.done", 32'(u1_done), 32'd1);
        chk("n1.c2.rd", 32'(u1_rd), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n1.c3.ready", 32'(u1_ready), 32'd1);
        chk("n1.c3.done", 32'(u1_done), 32'd0);
        chk("n1.c3.spk", 32'({u1_sv, u1_sa, u1_err}), 32'd0);
`ifdef NEURON_SWEEP_SPKCNT_EN
        chk("n1.c3.spk_cnt", 32'(u1_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
